// File: rtl/fifo_ctrl_pkg.sv
// Shared types and sizing helper for the FIFO write-arbiter controller.
package fifo_ctrl_pkg;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arbiter2
  import fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  grant_t last_grant_q, last_grant_d;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant_q == GNT_A) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[0])      last_grant_d = GNT_A;
    else if (gnt[1]) last_grant_d = GNT_B;
  end

  // NOTE: state registers use non-blocking assignments; the reset branch is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= GNT_B;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/fifo_write_arbiter_ctrl.sv
// FIFO controller with two arbitrated write producers and one reader,
// driving an external memory with one-cycle read latency.
module fifo_write_arbiter_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  gnt_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  gnt_b,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned         DEPTH  = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] HALF_C  = (ADDR_WIDTH+1)'(DEPTH / 2);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                full_q, empty_q, half_q, rd_valid_q;
  logic [1:0]          gnt;
  logic                wr_fire, rd_fire;

  // Grants are masked while full and while reset is held.
  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (!full_q && !rst),
    .req ({req_b, req_a}),
    .gnt (gnt)
  );

  assign gnt_a   = gnt[0];
  assign gnt_b   = gnt[1];
  assign wr_fire = gnt[0] | gnt[1];
  assign rd_fire = rd_req & ~empty_q & ~rst;

  assign mem_wr_en   = wr_fire;
  assign mem_data_in = gnt_b ? data_b : data_a;
  assign mem_waddr   = wptr_q[ADDR_WIDTH-1:0];
  assign mem_rd_en   = rd_fire;
  assign mem_raddr   = rptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wptr_d  = wr_fire ? wptr_q + ONE_C : wptr_q;
    rptr_d  = rd_fire ? rptr_q + ONE_C : rptr_q;
    count_d = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Flags come from next-state count so they line up with the count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      half_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == '0);
      half_q     <= (count_d == HALF_C);
      rd_valid_q <= rd_fire;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign half     = half_q;
  assign count    = count_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_fifo_write_arbiter_ctrl.sv
// Self-checking bench: vector table plus directed sequences, with a data scoreboard
// fed on granted writes and drained on rd_valid from a behavioural memory.
module tb_fifo_write_arbiter_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          gnt_a, gnt_b, rd_valid, mem_wr_en, mem_rd_en, full, empty, half;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_data_in;
  logic [AW:0]   count;

  fifo_write_arbiter_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
    .rd_req(rd_req), .rd_valid(rd_valid),
    .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_data_in(mem_data_in),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
    .full(full), .empty(empty), .half(half), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural memory with one-cycle read latency; never cleared by reset.
  logic [DW-1:0] tb_mem [0:DEPTH-1];
  logic [DW-1:0] mem_dout;
  always @(posedge clk) begin
    if (mem_wr_en) tb_mem[mem_waddr] <= mem_data_in;
    if (mem_rd_en) mem_dout <= tb_mem[mem_raddr];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_count;
  logic [AW:0] m_wptr, m_rptr;
  logic        m_last_b;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] prev_waddr;
  int          waddr_wraps;
  int          ptr_wraps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wptr = '0; m_rptr = '0; m_last_b = 1'b1;
    exp_q.delete();
    prev_waddr = '0;
  endtask

  task automatic apply_reset();
    req_a = 1'b1; req_b = 1'b1; rd_req = 1'b1; data_a = 8'hEE; data_b = 8'hDD;
    rst = 1'b1;
    #1;
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'd0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_half", 32'(half), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    model_reset();
    @(posedge clk); #1;
    check("rst_count_held", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; rd_req = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then registered ones.
  task automatic cycle(input logic ra, input logic [DW-1:0] da, input logic rb,
                       input logic [DW-1:0] db, input logic rr,
                       output logic ga, output logic gb, output logic [AW:0] cnt);
    logic e_ga, e_gb, e_rd, m_full, m_empty;
    logic [DW-1:0] wdata;
    req_a = ra; data_a = da; req_b = rb; data_b = db; rd_req = rr;
    #1;
    m_full  = (m_count == DEPTH);
    m_empty = (m_count == 0);
    e_ga = 1'b0; e_gb = 1'b0;
    if (!m_full) begin
      if (ra && rb) begin
        if (m_last_b) e_ga = 1'b1;
        else          e_gb = 1'b1;
      end else begin
        e_ga = ra; e_gb = rb;
      end
    end
    e_rd = rr && !m_empty;
    check("gnt_a", 32'(gnt_a), 32'(e_ga));
    check("gnt_b", 32'(gnt_b), 32'(e_gb));
    check("mem_wr_en", 32'(mem_wr_en), 32'(e_ga | e_gb));
    check("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    if (e_ga || e_gb) begin
      wdata = e_ga ? da : db;
      check("mem_waddr", 32'(mem_waddr), 32'(m_wptr[AW-1:0]));
      check("mem_data_in", 32'(mem_data_in), 32'(wdata));
      if (prev_waddr == 6'd63 && mem_waddr == 6'd0) waddr_wraps++;
      prev_waddr = mem_waddr;
      exp_q.push_back(wdata);
      if (m_wptr == 7'd127) ptr_wraps++;
      m_wptr   = m_wptr + 7'd1;
      m_last_b = e_gb;
    end
    if (e_rd) begin
      check("mem_raddr", 32'(mem_raddr), 32'(m_rptr[AW-1:0]));
      m_rptr = m_rptr + 7'd1;
    end
    m_count = m_count + ((e_ga || e_gb) ? 1 : 0) - (e_rd ? 1 : 0);
    ga = gnt_a; gb = gnt_b;
    @(posedge clk); #1;
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("empty", 32'(empty), 32'(m_count == 0));
    check("half", 32'(half), 32'(m_count == DEPTH / 2));
    check("rd_valid", 32'(rd_valid), 32'(e_rd));
    if (e_rd) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scoreboard_underflow: read with no expected data");
      end else begin
        check("rd_data", 32'(mem_dout), 32'(exp_q.pop_front()));
      end
    end
    cnt = count;
    @(negedge clk);
  endtask

  typedef struct {
    logic          ra;
    logic [DW-1:0] da;
    logic          rb;
    logic [DW-1:0] db;
    logic          rr;
    logic          ega;
    logic          egb;
    logic [AW:0]   ecnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic ga, gb;
    logic [AW:0] cnt;
    logic [DW-1:0] d;
    int rv_seen;

    vecs[0] = '{1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 7'd1};
    vecs[1] = '{1'b1, 8'hA1, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 7'd2};
    vecs[2] = '{1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 7'd3};
    vecs[3] = '{1'b1, 8'hA3, 1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 7'd4};
    vecs[4] = '{1'b0, 8'hA4, 1'b1, 8'hB4, 1'b0, 1'b0, 1'b1, 7'd5};
    vecs[5] = '{1'b1, 8'hA5, 1'b1, 8'hB5, 1'b1, 1'b1, 1'b0, 7'd5};
    vecs[6] = '{1'b0, 8'hA6, 1'b0, 8'hB6, 1'b1, 1'b0, 1'b0, 7'd4};
    vecs[7] = '{1'b0, 8'hA7, 1'b0, 8'hB7, 1'b0, 1'b0, 1'b0, 7'd4};
    waddr_wraps = 0;
    ptr_wraps   = 0;
    model_reset();

    @(negedge clk);
    apply_reset();

    // Round-robin table: A,B,A,B then mixed traffic
    foreach (vecs[i]) begin
      cycle(vecs[i].ra, vecs[i].da, vecs[i].rb, vecs[i].db, vecs[i].rr, ga, gb, cnt);
      check($sformatf("vec%0d_gnt_a", i), 32'(ga), 32'(vecs[i].ega));
      check($sformatf("vec%0d_gnt_b", i), 32'(gb), 32'(vecs[i].egb));
      check($sformatf("vec%0d_count", i), 32'(cnt), 32'(vecs[i].ecnt));
    end

    for (int i = 0; i < 2 * DEPTH && m_count != 0; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, ga, gb, cnt);
    check("drained_empty", 32'(empty), 32'd1);

    // Fill with A only
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i + 8'h40), 1'b0, '0, 1'b0, ga, gb, cnt);
      if (i == 30) check("half_before_32", 32'(half), 32'd0);
      if (i == 31) check("half_at_32", 32'(half), 32'd1);
      if (i == 62) check("full_at_63", 32'(full), 32'd0);
      if (i == 63) check("full_at_64", 32'(full), 32'd1);
    end
    cycle(1'b1, 8'hFF, 1'b0, '0, 1'b0, ga, gb, cnt);
    check("gnt_a_65th_when_full", 32'(ga), 32'd0);

    // Full: read proceeds, B held, then granted next cycle
    cycle(1'b0, '0, 1'b1, 8'hBE, 1'b1, ga, gb, cnt);
    check("full_rd_gnt_b_held", 32'(gb), 32'd0);
    check("full_rd_count", 32'(cnt), 32'd63);
    cycle(1'b0, '0, 1'b1, 8'hBE, 1'b0, ga, gb, cnt);
    check("full_next_gnt_b", 32'(gb), 32'd1);
    check("full_next_count", 32'(cnt), 32'd64);

    for (int i = 0; i < 2 * DEPTH && m_count != 0; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, ga, gb, cnt);

    // Three words then four reads; the fourth is refused
    cycle(1'b1, 8'h11, 1'b0, '0, 1'b0, ga, gb, cnt);
    cycle(1'b1, 8'h22, 1'b0, '0, 1'b0, ga, gb, cnt);
    cycle(1'b1, 8'h33, 1'b0, '0, 1'b0, ga, gb, cnt);
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0, '0, 1'b1, ga, gb, cnt);
      if (rd_valid) rv_seen++;
    end
    check("rd_valid_cycles", 32'(rv_seen), 32'd3);
    check("empty_after_reads", 32'(empty), 32'd1);

    // 130 writes interleaved with reads, alternating producers; first read hits empty
    for (int i = 0; i < 130; i++) begin
      d = 8'($urandom_range(0, 255));
      cycle(i[0] == 1'b0, d, i[0] == 1'b1, d, 1'b1, ga, gb, cnt);
    end
    check("waddr_wrap_seen", 32'(waddr_wraps != 0), 32'd1);
    check("ptr_wrap_seen", 32'(ptr_wraps != 0), 32'd1);
    for (int i = 0; i < 4 && m_count != 0; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, ga, gb, cnt);

    // Reset mid-burst at count 10, then the next write lands at address 0
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, '0, 1'b0, ga, gb, cnt);
    check("pre_reset_count", 32'(count), 32'd10);
    apply_reset();
    req_a = 1'b1; data_a = 8'h5A;
    #1;
    check("post_reset_waddr", 32'(mem_waddr), 32'd0);
    cycle(1'b1, 8'h5A, 1'b0, '0, 1'b0, ga, gb, cnt);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, ga, gb, cnt);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
